cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Arbitrates writeback results from N_REQ functional units onto the single common data bus (CDB).
- The CDB feeds reservation-station wakeup (wb_valid/wb_ready/wb_pd), ROB completion and the physical register file.
- Each FU port has a one-entry holding buffer. A round-robin scheduler drains these buffers into a registered CDB output stage with valid/ready backpressure. A pipeline flush discards everything in flight.

Parameters:
N_REQ, 4, number of FU writeback requesters (equals FU_NUM)
PHYS_W, 6, physical register tag width
DATA_W, 32, result data width
ROB_W, 5, ROB index width
SRC_W, $clog2(N_REQ), width of the source-FU index

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
req_valid  in  N_REQ  per-FU writeback valid
req_ready  out  N_REQ  per-FU accept; registered, equals !buf_valid[i]
req_pd  in  N_REQ*PHYS_W  destination physical tag per FU, FU i at bits [i*PHYS_W +: PHYS_W]
req_data  in  N_REQ*DATA_W  result data per FU
req_rob_idx  in  N_REQ*ROB_W  ROB index per FU
flush_valid  in  1  pipeline flush; discards all buffered and output results
cdb_valid  out  1  CDB result valid
cdb_ready  in  1  CDB consumer accept
cdb_pd  out  PHYS_W  broadcast physical tag
cdb_data  out  DATA_W  broadcast data
cdb_rob_idx  out  ROB_W  broadcast ROB index
cdb_src  out  SRC_W  FU index that produced the broadcast
busy  out  1  any buffer valid or cdb_valid

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - buf_valid all 0, cdb_valid 0, rr_ptr 0.
  - cdb_pd, cdb_data, cdb_rob_idx and cdb_src are 0.
  - req_ready is all 1; busy is 0.
  - Reset overrides flush and all handshakes in the same cycle.
- Input capture:
  - When req_valid[i] && req_ready[i], the payload is written to buf[i] and buf_valid[i] is set next cycle.
  - req_ready[i] = !buf_valid[i], driven from a register. There is no combinational path from cdb_ready or req_valid to req_ready.
  - A buffer drained in cycle t makes req_ready[i] go 1 in cycle t+1. Per-port throughput is therefore 1 result per 2 cycles.
- Output stage advance:
  - adv = !cdb_valid || cdb_ready.
  - When adv and any buf_valid is set:
    - Select the winner w as the first set buf_valid scanning rr_ptr, rr_ptr+1, … modulo N_REQ.
    - Load the output registers from buf[w] and set cdb_src = w and cdb_valid = 1.
    - Clear buf_valid[w].
    - Set rr_ptr <= (w+1) mod N_REQ. This wraps from N_REQ-1 to 0.
  - When adv and no buf_valid is set: cdb_valid <= 0 and rr_ptr holds.
  - When !adv (cdb_valid && !cdb_ready): all cdb_* outputs hold stable, no buffer is cleared, and rr_ptr holds.
- Latency: a request accepted at edge t appears on the CDB no earlier than the cycle after edge t+1. This is 1 cycle of input buffering plus the registered output.
- Aggregate throughput: 1 result per cycle when two or more ports are active.
- Same-port conflicts are impossible. Capture and drain of the same buffer cannot happen in one cycle because req_ready[i] is 0 while buf_valid[i] is set.
- Flush (flush_valid=1, rst_n=1):
  - Next cycle, buf_valid is all 0 and cdb_valid is 0.
  - Requests handshaken in the flush cycle are dropped.
  - rr_ptr holds its value.
  - Output data registers may hold stale values; they are don't-care while cdb_valid=0.
- busy = |buf_valid || cdb_valid, computed combinationally from registers.
- Assertions for verification:
  - cdb_* outputs are stable while cdb_valid && !cdb_ready.
  - Each accepted request appears on the CDB at most once and exactly once absent flush.
  - No port is skipped by more than N_REQ-1 grants while its buffer is valid.

Test Plan:
1. Single request: after reset, FU2 presents pd=0x11, data=0xDEADBEEF, rob=7 at cycle 0 with cdb_ready=1 -> req_ready[2]=0 in cycle 1; cdb_valid=1 in cycle 2 with pd=0x11, data=0xDEADBEEF, rob=7, src=2; rr_ptr=3 afterwards.
2. All-port burst: all four FUs request in cycle 0, cdb_ready=1 -> cdb_src sequence 0,1,2,3 in cycles 2..5; cdb_valid=0 in cycle 6; busy=0 in cycle 6.
3. Backpressure: as in scenario 2 but cdb_ready=0 for cycles 2..4 -> src=0 is held with identical pd/data/rob in cycles 2..4; src=1 appears in cycle 5; no result is lost or duplicated.
4. Round-robin wrap: rr_ptr=3, buffers 0 and 3 valid -> grant order is 3 then 0; rr_ptr ends at 1.
5. Flush mid-burst: all four requests in cycle 0, flush_valid=1 in cycle 3 -> cdb_valid=0 and busy=0 in cycle 4; only src 0 and 1 were broadcast; req_ready is all 1 in cycle 4.
6. Reset mid-operation: assert rst_n=0 while buffers are valid and cdb_valid=1 with cdb_ready=0 -> the next cycle has all outputs at reset values and rr_ptr=0; a new request after release is granted correctly.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding buffer per FU writeback port,
// round-robin drain into a registered CDB output stage with valid/ready.
`timescale 1ns/1ps
module cdb_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned PHYS_W = 6,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ROB_W  = 5,
  parameter int unsigned SRC_W  = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*PHYS_W-1:0]   req_pd,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ*ROB_W-1:0]    req_rob_idx,
  input  logic                      flush_valid,
  output logic                      cdb_valid,
  input  logic                      cdb_ready,
  output logic [PHYS_W-1:0]         cdb_pd,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [ROB_W-1:0]          cdb_rob_idx,
  output logic [SRC_W-1:0]          cdb_src,
  output logic                      busy
);

  localparam int unsigned CNT_W = SRC_W + 1;

  typedef struct packed {
    logic [PHYS_W-1:0] pd;
    logic [DATA_W-1:0] data;
    logic [ROB_W-1:0]  rob_idx;
  } wb_t;

  wb_t              req_pl_c [N_REQ];
  wb_t              hold_q   [N_REQ];
  logic [N_REQ-1:0] hold_vld_q;
  logic [N_REQ-1:0] hold_vld_nxt;
  logic [N_REQ-1:0] capture_c;
  logic [SRC_W-1:0] rr_ptr_q;
  logic [SRC_W-1:0] rr_ptr_nxt;
  logic [SRC_W-1:0] win_c;
  logic [CNT_W-1:0] scan_c;
  logic [CNT_W-1:0] win_inc_c;
  logic             any_c;
  logic             adv_c;
  logic             grant_c;
  logic             cdb_valid_nxt;

  // Slice the flat request buses into per-port payloads.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_pl_c[i].pd      = req_pd[i*PHYS_W +: PHYS_W];
      req_pl_c[i].data    = req_data[i*DATA_W +: DATA_W];
      req_pl_c[i].rob_idx = req_rob_idx[i*ROB_W +: ROB_W];
    end
  end

  assign capture_c = req_valid & req_ready;
  assign adv_c     = !cdb_valid || cdb_ready;
  // A flush suppresses the grant so rr_ptr and the buffers are not consumed.
  assign grant_c   = adv_c && any_c && !flush_valid;

  // Round-robin winner: first valid buffer scanning from rr_ptr upward, wrapping.
  always_comb begin
    any_c  = 1'b0;
    win_c  = '0;
    scan_c = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_c = CNT_W'(rr_ptr_q) + CNT_W'(k);
      if (scan_c >= CNT_W'(N_REQ)) begin
        scan_c = scan_c - CNT_W'(N_REQ);
      end
      if (!any_c && hold_vld_q[scan_c[SRC_W-1:0]]) begin
        any_c = 1'b1;
        win_c = scan_c[SRC_W-1:0];
      end
    end
  end

  // Next-state for buffer valids, round-robin pointer and output valid.
  always_comb begin
    hold_vld_nxt  = hold_vld_q;
    rr_ptr_nxt    = rr_ptr_q;
    cdb_valid_nxt = cdb_valid;
    win_inc_c     = CNT_W'(win_c) + CNT_W'(1);
    if (win_inc_c >= CNT_W'(N_REQ)) begin
      win_inc_c = '0;
    end
    if (grant_c) begin
      hold_vld_nxt[win_c] = 1'b0;
      rr_ptr_nxt          = win_inc_c[SRC_W-1:0];
    end
    hold_vld_nxt = hold_vld_nxt | capture_c;
    if (adv_c) begin
      cdb_valid_nxt = any_c;
    end
    if (flush_valid) begin
      hold_vld_nxt  = '0;
      cdb_valid_nxt = 1'b0;
    end
  end

  // Control registers and CDB output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_vld_q  <= '0;
      rr_ptr_q    <= '0;
      req_ready   <= '1;
      busy        <= 1'b0;
      cdb_valid   <= 1'b0;
      cdb_pd      <= '0;
      cdb_data    <= '0;
      cdb_rob_idx <= '0;
      cdb_src     <= '0;
    end else begin
      hold_vld_q <= hold_vld_nxt;
      rr_ptr_q   <= rr_ptr_nxt;
      req_ready  <= ~hold_vld_nxt;
      busy       <= (|hold_vld_nxt) || cdb_valid_nxt;
      cdb_valid  <= cdb_valid_nxt;
      if (grant_c) begin
        cdb_pd      <= hold_q[win_c].pd;
        cdb_data    <= hold_q[win_c].data;
        cdb_rob_idx <= hold_q[win_c].rob_idx;
        cdb_src     <= win_c;
      end
    end
  end

  // Payload buffers; contents are meaningless while the matching valid is clear.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (capture_c[i]) begin
        hold_q[i] <= req_pl_c[i];
      end
    end
  end

endmodule
